// File: rtl/fanout_buffered_base_pkg.sv
// -----------------------------------------------------------------------------
// fanout_buffered_base_pkg
// Shared constants, the lane payload record and a saturating-increment helper
// for the buffered fan-out distributor.
// -----------------------------------------------------------------------------
package fanout_buffered_base_pkg;

    // Width of the out-of-range drop counter.
    localparam int FANOUT_DROP_W = 16;

    // Default payload width used by the lane record.
    localparam int FANOUT_DATA_W = 32;

    // Payload record held by one output lane.
    typedef struct packed {
        logic [FANOUT_DATA_W-1:0] v;
    } fanout_lane_rec_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [FANOUT_DROP_W-1:0] drop_sat_inc(
        input logic [FANOUT_DROP_W-1:0] cnt
    );
        return (cnt == '1) ? cnt : cnt + FANOUT_DROP_W'(1);
    endfunction

endpackage

// File: rtl/fanout_buffered_base_if.sv
// -----------------------------------------------------------------------------
// fanout_buffered_base_if
// Bundles the single input enqueue stream and the per-lane output enqueue
// ports of the fan-out distributor.
//   in_enq__ENA / in_enq_v / in_enq_dest : producer -> distributor
//   in_enq__RDY                          : distributor -> producer
//   out_enq__ENA / out_enq_v             : distributor -> consumers (per lane)
//   out_enq__RDY                         : consumers -> distributor (per lane)
// Modports: master = producer/consumer side, slave = distributor.
// -----------------------------------------------------------------------------
interface fanout_buffered_base_if #(
    parameter int funnelWidth = 99,
    parameter int dataWidth   = 32,
    parameter int destWidth   = (funnelWidth > 1) ? $clog2(funnelWidth) : 1
);

    logic                   in_enq__ENA;
    logic [dataWidth-1:0]   in_enq_v;
    logic [destWidth-1:0]   in_enq_dest;
    logic                   in_enq__RDY;

    logic [funnelWidth-1:0] out_enq__ENA;
    logic [dataWidth-1:0]   out_enq_v [funnelWidth];
    logic [funnelWidth-1:0] out_enq__RDY;

    modport master (
        output in_enq__ENA,
        output in_enq_v,
        output in_enq_dest,
        input  in_enq__RDY,
        input  out_enq__ENA,
        input  out_enq_v,
        output out_enq__RDY
    );

    modport slave (
        input  in_enq__ENA,
        input  in_enq_v,
        input  in_enq_dest,
        output in_enq__RDY,
        output out_enq__ENA,
        output out_enq_v,
        input  out_enq__RDY
    );

endinterface

// File: rtl/fanout_lane_fifo.sv
// -----------------------------------------------------------------------------
// fanout_lane_fifo
// Single-entry pass-through buffer for one output lane. An entry may be
// dequeued and replaced in the same cycle, so a ready consumer sees one item
// per cycle.
//   clk_i, rst_ni           : clock, synchronous active-low reset
//   enq_ena_i, enq_v_i      : load strobe and payload
//   enq_rdy_o               : buffer can take a load this cycle
//   deq_ena_i               : consumer takes the current entry
//   deq_rdy_o, deq_v_o      : entry present, entry payload
// -----------------------------------------------------------------------------
module fanout_lane_fifo #(
    parameter int width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enq_ena_i,
    input  logic [width-1:0] enq_v_i,
    output logic             enq_rdy_o,
    input  logic             deq_ena_i,
    output logic             deq_rdy_o,
    output logic [width-1:0] deq_v_o
);

    logic             valid_q, valid_d;
    logic [width-1:0] v_q, v_d;

    // Empty, or the current entry leaves this cycle (pass-through).
    assign enq_rdy_o = !valid_q || deq_ena_i;
    assign deq_rdy_o = valid_q;
    assign deq_v_o   = v_q;

    always_comb begin
        valid_d = valid_q;
        v_d     = v_q;
        if (enq_ena_i) begin
            valid_d = 1'b1;
            v_d     = enq_v_i;
        end else if (deq_ena_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            v_q     <= '0;
        end else begin
            valid_q <= valid_d;
            v_q     <= v_d;
        end
    end

endmodule

// File: rtl/fanout_buffered_base.sv
// -----------------------------------------------------------------------------
// fanout_buffered_base
// One-to-many distributor. Items enter a single hold register together with a
// destination index, then move into that lane's single-entry buffer. Items
// with an out-of-range destination are discarded from the hold register and
// counted in dropCount (saturating).
//   CLK        : clock, rising edge
//   nRST       : synchronous active-low reset
//   io         : enqueue input stream and per-lane output ports (slave side)
//   dropCount  : number of discarded out-of-range items
// -----------------------------------------------------------------------------
module fanout_buffered_base
    import fanout_buffered_base_pkg::*;
#(
    parameter int funnelWidth = 99,
    parameter int dataWidth   = 32,
    parameter int destWidth   = (funnelWidth > 1) ? $clog2(funnelWidth) : 1
) (
    input  logic                     CLK,
    input  logic                     nRST,
    fanout_buffered_base_if.slave    io,
    output logic [FANOUT_DROP_W-1:0] dropCount
);

    localparam logic [31:0] LANE_COUNT = funnelWidth;

    // Hold stage
    logic                     hold_valid_q, hold_valid_d;
    logic [dataWidth-1:0]     hold_v_q, hold_v_d;
    logic [destWidth-1:0]     hold_dest_q, hold_dest_d;
    logic [FANOUT_DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [31:0]              hold_dest_ext;
    logic                     hold_in_range;
    logic                     hold_drain;
    logic                     hold_drop;
    logic                     in_rdy;
    logic                     in_fire;

    // Per-lane
    logic [funnelWidth-1:0]   lane_accept;
    logic [funnelWidth-1:0]   lane_load;
    logic [funnelWidth-1:0]   lane_valid;
    logic [funnelWidth-1:0]   out_fire;

    assign hold_dest_ext = {{(32-destWidth){1'b0}}, hold_dest_q};
    assign hold_in_range = (hold_dest_ext < LANE_COUNT);

    // Only the lane addressed by the hold register can load; this avoids
    // indexing lane_accept with a possibly out-of-range destination.
    assign hold_drop  = hold_valid_q && !hold_in_range;
    assign hold_drain = hold_drop || (|lane_load);

    // The guard never looks at the incoming destination.
    assign in_rdy  = nRST && (!hold_valid_q || hold_drain);
    assign in_fire = io.in_enq__ENA && in_rdy;

    assign io.in_enq__RDY  = in_rdy;
    assign io.out_enq__ENA = out_fire;
    assign dropCount       = drop_cnt_q;

    for (genvar gi = 0; gi < funnelWidth; gi++) begin : g_lane
        assign lane_load[gi] = hold_valid_q
                            && (hold_dest_q == destWidth'(gi))
                            && lane_accept[gi];

        // Gated by nRST so nothing is emitted during a reset cycle.
        assign out_fire[gi]  = nRST && lane_valid[gi] && io.out_enq__RDY[gi];

        fanout_lane_fifo #(
            .width (dataWidth)
        ) u_lane (
            .clk_i     (CLK),
            .rst_ni    (nRST),
            .enq_ena_i (lane_load[gi]),
            .enq_v_i   (hold_v_q),
            .enq_rdy_o (lane_accept[gi]),
            .deq_ena_i (out_fire[gi]),
            .deq_rdy_o (lane_valid[gi]),
            .deq_v_o   (io.out_enq_v[gi])
        );
    end

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_v_d     = hold_v_q;
        hold_dest_d  = hold_dest_q;
        drop_cnt_d   = drop_cnt_q;

        // A new item may replace a draining one on the same edge.
        if (in_fire) begin
            hold_valid_d = 1'b1;
            hold_v_d     = io.in_enq_v;
            hold_dest_d  = io.in_enq_dest;
        end else if (hold_drain) begin
            hold_valid_d = 1'b0;
        end

        if (hold_drop) begin
            drop_cnt_d = drop_sat_inc(drop_cnt_q);
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            hold_valid_q <= 1'b0;
            hold_v_q     <= '0;
            hold_dest_q  <= '0;
            drop_cnt_q   <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_v_q     <= hold_v_d;
            hold_dest_q  <= hold_dest_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

endmodule
